// File: rtl/viola_pkg.sv
// ----------------------------------------------------------------------------
// viola_pkg
// Shared definitions for the ALU reservation station and its selector:
//   - 5-bit opcode encodings (ADD .. JAL_C) and the NOP_OP "no op" marker
//   - is_load_store(): identifies opcodes owned by the load/store buffer
//   - DEF_TAG_W: default ROB tag width (tag 0 = no dependency / no result)
// ----------------------------------------------------------------------------
package viola_pkg;

  localparam int DEF_TAG_W = 3;

  localparam logic [4:0] ADD    = 5'd0;
  localparam logic [4:0] SUB    = 5'd1;
  localparam logic [4:0] SLL    = 5'd2;
  localparam logic [4:0] SLT    = 5'd3;
  localparam logic [4:0] SLTU   = 5'd4;
  localparam logic [4:0] XOR_OP = 5'd5;
  localparam logic [4:0] SRL    = 5'd6;
  localparam logic [4:0] SRA    = 5'd7;
  localparam logic [4:0] OR_OP  = 5'd8;
  localparam logic [4:0] AND_OP = 5'd9;
  localparam logic [4:0] BEQ    = 5'd10;
  localparam logic [4:0] BNE    = 5'd11;
  localparam logic [4:0] BLT    = 5'd12;
  localparam logic [4:0] BGE    = 5'd13;
  localparam logic [4:0] BLTU   = 5'd14;
  localparam logic [4:0] BGEU   = 5'd15;
  localparam logic [4:0] JALR   = 5'd16;
  localparam logic [4:0] AUIPC  = 5'd17;
  // Loads and stores occupy 5'b10010 .. 5'b11001.
  localparam logic [4:0] LB     = 5'd18;
  localparam logic [4:0] LH     = 5'd19;
  localparam logic [4:0] LW     = 5'd20;
  localparam logic [4:0] LBU    = 5'd21;
  localparam logic [4:0] LHU    = 5'd22;
  localparam logic [4:0] SB     = 5'd23;
  localparam logic [4:0] SH     = 5'd24;
  localparam logic [4:0] SW     = 5'd25;
  localparam logic [4:0] LUI    = 5'd26;
  localparam logic [4:0] JAL_C  = 5'd27;
  localparam logic [4:0] NOP_OP = 5'b11111;

  function automatic logic is_load_store(input logic [4:0] op);
    return (op >= LB) && (op <= SW);
  endfunction

endpackage

// File: rtl/rs_select.sv
// ----------------------------------------------------------------------------
// rs_select
// Combinational issue picker for the reservation station.
// Optional feature macro: RS_AGE_ORDER_EN
//   undefined : grant = lowest-index ready entry
//   defined   : grant = ready entry with the largest age, ties to lowest index
// Ports:
//   ready [DEPTH]        entries eligible to issue
//   age   [DEPTH][IDX_W] per-entry age (RS_AGE_ORDER_EN only)
//   grant [IDX_W]        selected entry index (0 when valid is low)
//   valid                at least one entry is ready
// ----------------------------------------------------------------------------
module rs_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            ready,
`ifdef RS_AGE_ORDER_EN
  input  logic [DEPTH-1:0][IDX_W-1:0] age,
`endif
  output logic [IDX_W-1:0]            grant,
  output logic                        valid
);

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0] best_age;

  // Strict '>' keeps the earlier (lower) index on equal ages.
  always_comb begin
    valid    = 1'b0;
    grant    = '0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!valid || age[i] > best_age)) begin
        valid    = 1'b1;
        grant    = IDX_W'(i);
        best_age = age[i];
      end
    end
  end
`else
  // Scanning downward lets the lowest ready index win the last assignment.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ready[i]) begin
        valid = 1'b1;
        grant = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_reservation_station.sv
// ----------------------------------------------------------------------------
// alu_reservation_station
// Holds ALU / branch / JALR ops from the ROB until both operands are known,
// snooping the ALU and memory result buses by ROB tag, and issues one ready
// op per cycle to the ALU.
// Optional feature macro: RS_AGE_ORDER_EN (oldest-ready-first issue).
// Ports:
//   clk, rst                 clock; synchronous active-high reset / flush
//   op_in                    dispatched opcode (NOP_OP = no dispatch)
//   value1_in/query1_in      operand 1 value / producing tag (0 = ready)
//   value2_in/query2_in      operand 2 value / producing tag (0 = ready)
//   imm_in, target_in        immediate and this op's ROB tag
//   alu_num/alu_value        ALU result broadcast (tag 0 = idle)
//   mem_num/mem_value        memory result broadcast (tag 0 = idle)
//   rs_full                  registered back-pressure to the ROB
//   issue_op/v1/v2/imm/tag   registered issue to the ALU (NOP_OP, tag 0 idle)
// ----------------------------------------------------------------------------
module alu_reservation_station
  import viola_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       op_in,
  input  logic [31:0]      value1_in,
  input  logic [31:0]      value2_in,
  input  logic [TAG_W-1:0] query1_in,
  input  logic [TAG_W-1:0] query2_in,
  input  logic [31:0]      imm_in,
  input  logic [TAG_W-1:0] target_in,
  input  logic [TAG_W-1:0] alu_num,
  input  logic [31:0]      alu_value,
  input  logic [TAG_W-1:0] mem_num,
  input  logic [31:0]      mem_value,
  output logic             rs_full,
  output logic [4:0]       issue_op,
  output logic [31:0]      issue_v1,
  output logic [31:0]      issue_v2,
  output logic [31:0]      issue_imm,
  output logic [TAG_W-1:0] issue_tag
);

  localparam int IDX_W = $clog2(DEPTH);

  // Entry storage
  logic [DEPTH-1:0] busy;
  logic [4:0]       op_q  [DEPTH];
  logic [31:0]      v1_q  [DEPTH];
  logic [31:0]      v2_q  [DEPTH];
  logic [31:0]      imm_q [DEPTH];
  logic [TAG_W-1:0] q1_q  [DEPTH];
  logic [TAG_W-1:0] q2_q  [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
`ifdef RS_AGE_ORDER_EN
  logic [DEPTH-1:0][IDX_W-1:0] age_q;
`endif

  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] grant;
  logic             grant_valid;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;
  logic             dispatch_take;
  logic             dispatch_en;
  logic [31:0]      d_v1, d_v2;
  logic [TAG_W-1:0] d_q1, d_q2;
  logic [DEPTH-1:0] next_busy;

  // Readiness is judged on registered state, so an entry woken at this edge
  // cannot issue before the following one.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
    end
  end

  rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .ready (ready),
`ifdef RS_AGE_ORDER_EN
    .age   (age_q),
`endif
    .grant (grant),
    .valid (grant_valid)
  );

  // Free slot comes from pre-issue occupancy: a slot issuing at this edge is
  // still seen as busy and becomes reusable only from the next edge.
  // NOTE: every combinational output gets a default at the top of the block,
  // otherwise a path that skips an assignment infers a latch.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign dispatch_take = (op_in != NOP_OP) && !is_load_store(op_in);
  assign dispatch_en   = dispatch_take && free_found;

  // Same-cycle bypass of a broadcast into the dispatched operands; the ALU
  // bus wins when both buses carry the same tag.
  // NOTE: blocking '=' in combinational logic, non-blocking '<=' for state.
  always_comb begin
    d_v1 = value1_in;
    d_q1 = query1_in;
    d_v2 = value2_in;
    d_q2 = query2_in;
    if (query1_in != '0 && query1_in == alu_num) begin
      d_v1 = alu_value;
      d_q1 = '0;
    end else if (query1_in != '0 && query1_in == mem_num) begin
      d_v1 = mem_value;
      d_q1 = '0;
    end
    if (query2_in != '0 && query2_in == alu_num) begin
      d_v2 = alu_value;
      d_q2 = '0;
    end else if (query2_in != '0 && query2_in == mem_num) begin
      d_v2 = mem_value;
      d_q2 = '0;
    end
  end

  always_comb begin
    next_busy = busy;
    if (grant_valid) next_busy[grant] = 1'b0;
    if (dispatch_en) next_busy[free_idx] = 1'b1;
  end

  // Control state and issue registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      rs_full   <= 1'b0;
      issue_op  <= NOP_OP;
      issue_tag <= '0;
      issue_v1  <= '0;
      issue_v2  <= '0;
      issue_imm <= '0;
    end else begin
      busy    <= next_busy;
      // One slot of headroom covers the dispatch already in flight.
      rs_full <= ($countones(next_busy) >= DEPTH - 1);
      if (grant_valid) begin
        issue_op  <= op_q[grant];
        issue_tag <= tag_q[grant];
        issue_v1  <= v1_q[grant];
        issue_v2  <= v2_q[grant];
        issue_imm <= imm_q[grant];
      end else begin
        issue_op  <= NOP_OP;
        issue_tag <= '0;
      end
    end
  end

  // Entry payload. Only the busy bits qualify these fields, so they need no
  // reset; a flush simply leaves stale contents behind idle entries.
  // NOTE: storage arrays are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (busy[i]) begin
        if (q1_q[i] != '0 && q1_q[i] == alu_num) begin
          v1_q[i] <= alu_value;
          q1_q[i] <= '0;
        end else if (q1_q[i] != '0 && q1_q[i] == mem_num) begin
          v1_q[i] <= mem_value;
          q1_q[i] <= '0;
        end
        if (q2_q[i] != '0 && q2_q[i] == alu_num) begin
          v2_q[i] <= alu_value;
          q2_q[i] <= '0;
        end else if (q2_q[i] != '0 && q2_q[i] == mem_num) begin
          v2_q[i] <= mem_value;
          q2_q[i] <= '0;
        end
`ifdef RS_AGE_ORDER_EN
        if (age_q[i] != '1) age_q[i] <= age_q[i] + 1'b1;
`endif
      end
    end
    // The free slot is never busy, so this cannot collide with wakeup above.
    if (dispatch_en) begin
      op_q[free_idx]  <= op_in;
      v1_q[free_idx]  <= d_v1;
      q1_q[free_idx]  <= d_q1;
      v2_q[free_idx]  <= d_v2;
      q2_q[free_idx]  <= d_q2;
      imm_q[free_idx] <= imm_in;
      tag_q[free_idx] <= target_in;
`ifdef RS_AGE_ORDER_EN
      age_q[free_idx] <= '0;
`endif
    end
  end

  // The ROB must honour rs_full; a dispatch with no free slot would be lost.
  dispatch_dropped: assert property (@(posedge clk) disable iff (rst)
    !(dispatch_take && !free_found));

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Buffers decoded ALU, branch and JALR operations dispatched by the reorder buffer until both source operands are available, then issues one op per cycle to the ALU.
- Snoops the ALU and memory result broadcasts, indexed by ROB tag, to wake up waiting operands.
- Sits between the ROB dispatch outputs and the ALU input. Its full flag drives the ROB's rs_full input.

Parameters:
- DEPTH, 4, number of station entries (2..8).
- TAG_W, 3, ROB tag width; tag 0 means "no dependency / no result".

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset; also used as the pipeline flush.
- op_in  in  5  dispatched opcode; 5'b11111 means no dispatch this cycle.
- value1_in  in  32  operand 1 value, valid when query1_in==0.
- value2_in  in  32  operand 2 value (or immediate), valid when query2_in==0.
- query1_in  in  TAG_W  ROB tag that produces operand 1; 0 means ready.
- query2_in  in  TAG_W  ROB tag that produces operand 2; 0 means ready.
- imm_in  in  32  immediate; forwarded for branch and JALR.
- target_in  in  TAG_W  ROB entry of this instruction.
- alu_num  in  TAG_W  ALU broadcast tag; 0 means idle.
- alu_value  in  32  ALU broadcast value.
- mem_num  in  TAG_W  memory broadcast tag; 0 means idle.
- mem_value  in  32  memory broadcast value.
- rs_full  out  1  asserted when the station cannot absorb another dispatch.
- issue_op  out  5  issued opcode; 5'b11111 when idle.
- issue_v1  out  32  issued operand 1.
- issue_v2  out  32  issued operand 2.
- issue_imm  out  32  issued immediate.
- issue_tag  out  TAG_W  ROB tag of the issued op; 0 when idle.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset, sampled at posedge:
  - All entries are cleared to not busy.
  - Outputs: issue_op=5'b11111, issue_tag=0, issue_v1/v2/imm=0, rs_full=0.
  - Reset mid-operation discards all held ops. No issue occurs in the reset cycle.
- Entry fields: busy, op, v1, q1, v2, q2, imm, tag.
- Dispatch:
  - A dispatch is taken when op_in!=5'b11111 and op_in is not a load/store (5'b10010..5'b11001).
  - Load/store opcodes are ignored; the load/store buffer owns them.
  - The op is written to the lowest-index non-busy entry, chosen from the pre-issue state.
  - Dispatch while no entry is free is a protocol violation; the dispatch is dropped, which assertions must catch.
- Dispatch bypass: if query1_in or query2_in is nonzero and equals alu_num or mem_num in the same cycle, store the broadcast value and set that q to 0.
  - When both buses carry the same tag, alu_num takes priority.
- Wakeup: for every busy entry, if q1 or q2 is nonzero and matches alu_num or mem_num (alu_num first), capture the value and set q to 0 at that posedge.
- Issue:
  - Each posedge, select one busy entry with q1==0 and q2==0, using the registered state from before this edge's wakeup.
  - Register its fields to the issue_* outputs, then clear its busy bit.
  - If no entry is ready, drive issue_op=5'b11111 and issue_tag=0. Data outputs hold their previous values.
  - Latency: an op dispatched with both operands ready appears on issue_* in the cycle after its dispatch edge.
  - An op woken at edge N issues at edge N+1 at the earliest.
- Same-edge events:
  - Dispatch into a free slot and issue from another slot may occur at the same edge.
  - An issued slot is reusable only from the next edge.
- rs_full, registered: 1 when the post-update busy count is at least DEPTH-1. This leaves one slot of headroom for the dispatch already in flight from the ROB.
- Selection without the optional feature: lowest index among ready entries.

Optional Feature:
- Macro: RS_AGE_ORDER_EN.
- When defined:
  - Each entry carries an age counter of width clog2(DEPTH). It is set to 0 on dispatch and incremented (saturating) for every busy entry at each edge.
  - Issue picks the ready entry with the largest age; ties go to the lowest index.
- When undefined: lowest-index ready entry issues, and no age storage exists.

Decomposition:
- Shared package viola_pkg:
  - Opcode localparams (ADD..JAL_C), NOP_OP=5'b11111.
  - The is_load_store function.
  - The TAG_W default.
- One sub-module, rs_select:
  - Input: ready vector (plus ages under RS_AGE_ORDER_EN).
  - Output: grant index and a valid bit.
  - Combinational priority/age picker.

Test Plan:
- Ready dispatch: ADD with q1=q2=0, v1=5, v2=7, target=3 -> next cycle issue_op=ADD, v1=5, v2=7, issue_tag=3; following cycle issue_tag=0.
- Wakeup: SUB with q1=2 -> no issue. Then alu_num=2, alu_value=0x10 -> SUB issues one edge later with v1=0x10.
- Dispatch bypass: BEQ with q2=4 while mem_num=4, mem_value=9 in the same cycle -> next cycle issue_op=BEQ, v2=9, imm passed through.
- Full: four dependent ops (q1=5), no broadcast -> rs_full=1 after the third; load op_in=LW is ignored with no state change.
- Issue order: entries 0 and 1 become ready on the same edge, with entry 1 dispatched first -> without macro entry 0 issues first; with RS_AGE_ORDER_EN entry 1 issues first.
- Flush: rst=1 with three busy entries -> next cycle issue_op=5'b11111, rs_full=0; a later broadcast of their tags produces no issue.
